// File: rtl/adsr_envelope.sv
// ADSR envelope generator: shapes a 10-bit amplitude from a note gate,
// updating on a fixed-rate tick derived from the system clock.
module adsr_envelope #(
    parameter int CLKSPEED = 48_000_000,
    parameter int TICK_HZ  = 48_000,
    parameter int AMP_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate,
    input  logic [7:0]       attack_rate,
    input  logic [7:0]       decay_rate,
    input  logic [AMP_W-1:0] sustain_level,
    input  logic [7:0]       release_rate,
    output logic [AMP_W-1:0] amp,
    output logic [2:0]       stage,
    output logic             busy
);

    localparam int DIV   = CLKSPEED / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TC      = CNT_W'(DIV - 1);
    localparam logic [AMP_W-1:0] AMP_MAX = '1;
    localparam logic signed [AMP_W+1:0] ZERO = '0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             g1, g2, g3;
    logic             rise, fall;

    logic        [AMP_W:0]   attack_sum;
    logic signed [AMP_W+1:0] decay_diff;
    logic signed [AMP_W+1:0] release_diff;
    logic signed [AMP_W+1:0] sustain_ext;

    // Free-running divider; gate activity never restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g1 <= 1'b0;
            g2 <= 1'b0;
            g3 <= 1'b0;
        end else begin
            g1 <= gate;
            g2 <= g1;
            g3 <= g2;
        end
    end

    assign rise = g2 & ~g3;
    assign fall = ~g2 & g3;

    // Subtractions are signed and two bits wider so a large rate cannot wrap.
    assign attack_sum   = {1'b0, amp} + {{(AMP_W-7){1'b0}}, attack_rate};
    assign decay_diff   = $signed({2'b00, amp}) - $signed({{(AMP_W-6){1'b0}}, decay_rate});
    assign release_diff = $signed({2'b00, amp}) - $signed({{(AMP_W-6){1'b0}}, release_rate});
    assign sustain_ext  = $signed({2'b00, sustain_level});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            amp   <= '0;
            busy  <= 1'b0;
        end else if (rise && (state == IDLE || state == RELEASE)) begin
            state <= ATTACK;
            busy  <= 1'b1;
        end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state <= RELEASE;
            busy  <= 1'b1;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    amp <= '0;
                end
                ATTACK: begin
                    if (attack_rate == 8'd0 || attack_sum >= {1'b0, AMP_MAX}) begin
                        amp   <= AMP_MAX;
                        state <= DECAY;
                    end else begin
                        amp <= attack_sum[AMP_W-1:0];
                    end
                end
                DECAY: begin
                    if (amp <= sustain_level || decay_rate == 8'd0 || decay_diff <= sustain_ext) begin
                        amp   <= sustain_level;
                        state <= SUSTAIN;
                    end else begin
                        amp <= decay_diff[AMP_W-1:0];
                    end
                end
                SUSTAIN: begin
                    amp <= sustain_level;
                end
                RELEASE: begin
                    if (release_rate == 8'd0 || release_diff <= ZERO) begin
                        amp   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        amp <= release_diff[AMP_W-1:0];
                    end
                end
                default: begin
                    amp   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign stage = state;

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: the stimulus queues hand-computed
// expectations by cycle number and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_adsr_envelope;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gate = 1'b0;
    logic [7:0] attack_rate = 8'd0;
    logic [7:0] decay_rate = 8'd0;
    logic [7:0] release_rate = 8'd0;
    logic [9:0] sustain_level = 10'd0;
    logic [9:0] amp;
    logic [2:0] stage;
    logic       busy;

    typedef struct {
        int         cyc;
        logic [9:0] amp;
        logic [2:0] stage;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_item;
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    adsr_envelope #(
        .CLKSPEED(1000),
        .TICK_HZ (100),
        .AMP_W   (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gate         (gate),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .sustain_level(sustain_level),
        .release_rate (release_rate),
        .amp          (amp),
        .stage        (stage),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Edge number since the last reset release; tick edges fall on multiples of 10.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [9:0] exp_amp, input logic [2:0] exp_stage);
        logic exp_busy;
        exp_busy = (exp_stage != 3'd0);
        n_compared++;
        if (amp !== exp_amp || stage !== exp_stage || busy !== exp_busy) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got amp=%0d stage=%0d busy=%0b, expected amp=%0d stage=%0d busy=%0b",
                     name, amp, stage, busy, exp_amp, exp_stage, exp_busy);
        end
    endtask

    task automatic expectAt(input int c, input logic [9:0] a, input logic [2:0] s, input string name);
        exp_t e;
        e.cyc   = c;
        e.amp   = a;
        e.stage = s;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic waitCycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int after_edge, input logic g, input logic [7:0] ar,
                                 input logic [7:0] dr, input logic [7:0] rr, input logic [9:0] sl);
        waitCycle(after_edge);
        gate          = g;
        attack_rate   = ar;
        decay_rate    = dr;
        release_rate  = rr;
        sustain_level = sl;
    endtask

    task automatic drainQueue(input string name);
        for (int i = 0; i < 60 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s: %0d expectations left unchecked, expected 0", name, sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_item = sb.pop_front();
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL %s: not sampled at cycle %0d (now %0d)", mon_item.name, mon_item.cyc, cyc);
            end
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_item = sb.pop_front();
                checkOutput(mon_item.name, mon_item.amp, mon_item.stage);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        expectAt(1,   10'd0, 3'd0, "idle_c1");
        expectAt(9,   10'd0, 3'd0, "idle_c9");
        expectAt(10,  10'd0, 3'd0, "idle_tick10");
        expectAt(50,  10'd0, 3'd0, "idle_c50");
        expectAt(100, 10'd0, 3'd0, "idle_c100");
        // Full attack, instant decay to sustain, then live sustain change
        expectAt(102, 10'd0,    3'd0, "sync_edge2");
        expectAt(103, 10'd0,    3'd1, "sync_edge3_attack");
        expectAt(109, 10'd0,    3'd1, "attack_pretick");
        expectAt(110, 10'd100,  3'd1, "attack_1");
        expectAt(150, 10'd500,  3'd1, "attack_5");
        expectAt(200, 10'd1000, 3'd1, "attack_10");
        expectAt(210, 10'd1023, 3'd2, "attack_sat");
        expectAt(220, 10'd600,  3'd3, "decay_instant");
        expectAt(240, 10'd400,  3'd3, "sustain_track");
        rst = 1'b0;
        applyStimulus(100, 1'b1, 8'd100, 8'd0, 8'd128, 10'd600);
        applyStimulus(232, 1'b1, 8'd100, 8'd0, 8'd128, 10'd400);

        // Fall detected on a tick edge: edge wins, amp held
        expectAt(250, 10'd500, 3'd3, "sustain_500");
        expectAt(259, 10'd500, 3'd3, "pre_collision");
        expectAt(260, 10'd500, 3'd4, "collision_fall");
        expectAt(270, 10'd372, 3'd4, "release_1");
        expectAt(290, 10'd116, 3'd4, "release_3");
        expectAt(300, 10'd0,   3'd0, "release_floor");
        applyStimulus(242, 1'b1, 8'd100, 8'd0, 8'd128, 10'd500);
        applyStimulus(257, 1'b0, 8'd100, 8'd0, 8'd128, 10'd500);

        // Release from attack, retrigger in release, release to idle
        expectAt(303, 10'd0,   3'd1, "attack_from_idle");
        expectAt(330, 10'd300, 3'd1, "attack_300");
        expectAt(333, 10'd300, 3'd4, "release_hold");
        expectAt(340, 10'd172, 3'd4, "release_172");
        expectAt(343, 10'd172, 3'd1, "retrigger_keep");
        expectAt(350, 10'd272, 3'd1, "retrigger_step");
        expectAt(355, 10'd272, 3'd4, "release2_hold");
        expectAt(360, 10'd144, 3'd4, "release2_144");
        expectAt(370, 10'd16,  3'd4, "release2_16");
        expectAt(380, 10'd0,   3'd0, "release2_idle");
        applyStimulus(300, 1'b1, 8'd100, 8'd0, 8'd128, 10'd500);
        applyStimulus(330, 1'b0, 8'd100, 8'd0, 8'd128, 10'd500);
        applyStimulus(340, 1'b1, 8'd100, 8'd0, 8'd128, 10'd500);
        applyStimulus(352, 1'b0, 8'd100, 8'd0, 8'd128, 10'd500);

        // Instant attack, stepped decay to sustain, sustain change
        expectAt(393, 10'd0,    3'd1, "attack2_start");
        expectAt(400, 10'd1023, 3'd2, "attack_instant");
        expectAt(410, 10'd973,  3'd2, "decay_1");
        expectAt(480, 10'd623,  3'd2, "decay_8");
        expectAt(490, 10'd600,  3'd3, "decay_to_sustain");
        expectAt(500, 10'd400,  3'd3, "sustain_400");
        applyStimulus(382, 1'b0, 8'd0, 8'd50, 8'd128, 10'd600);
        applyStimulus(390, 1'b1, 8'd0, 8'd50, 8'd128, 10'd600);
        applyStimulus(492, 1'b1, 8'd0, 8'd50, 8'd0,   10'd400);

        // Instant release, new attack, then async reset mid-attack
        expectAt(503, 10'd400, 3'd4, "release3_hold");
        expectAt(510, 10'd0,   3'd0, "release_instant");
        expectAt(515, 10'd0,   3'd1, "attack3_start");
        expectAt(520, 10'd100, 3'd1, "attack3_1");
        expectAt(530, 10'd200, 3'd1, "attack3_2");
        applyStimulus(500, 1'b0, 8'd0,   8'd50, 8'd0, 10'd400);
        applyStimulus(505, 1'b0, 8'd100, 8'd50, 8'd0, 10'd400);
        applyStimulus(512, 1'b1, 8'd100, 8'd50, 8'd0, 10'd400);
        waitCycle(532);
        drainQueue("drain_pre_reset");

        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 10'd0, 3'd0);
        expectAt(2,  10'd0,   3'd0, "post_reset_edge2");
        expectAt(3,  10'd0,   3'd1, "post_reset_attack");
        expectAt(9,  10'd0,   3'd1, "post_reset_pretick");
        expectAt(10, 10'd100, 3'd1, "post_reset_tick");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        waitCycle(10);
        drainQueue("drain_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
